// File: rtl/div_if.sv
// div_if: divider request/result and shared-alu signals between core and div_seq.
// Ports (signals):
//   Div_Start, Div_Op[1:0], Div_A, Div_B      request from core
//   Div_Busy, Div_Done, Div_Result            status/result to core
//   Alu_A, Alu_B, Alu_Op[3:0]                 operands/opcode to the shared alu
//   Alu_Result                                combinational alu output back
// Modports: master = core/alu side, slave = div_seq.
interface div_if #(parameter int DWIDTH = 32);
    logic              Div_Start;
    logic [1:0]        Div_Op;
    logic [DWIDTH-1:0] Div_A;
    logic [DWIDTH-1:0] Div_B;
    logic              Div_Busy;
    logic              Div_Done;
    logic [DWIDTH-1:0] Div_Result;
    logic [DWIDTH-1:0] Alu_A;
    logic [DWIDTH-1:0] Alu_B;
    logic [3:0]        Alu_Op;
    logic [DWIDTH-1:0] Alu_Result;
    modport master (
        output Div_Start, Div_Op, Div_A, Div_B, Alu_Result,
        input  Div_Busy, Div_Done, Div_Result, Alu_A, Alu_B, Alu_Op
    );
    modport slave (
        input  Div_Start, Div_Op, Div_A, Div_B, Alu_Result,
        output Div_Busy, Div_Done, Div_Result, Alu_A, Alu_B, Alu_Op
    );
endinterface

// File: rtl/div_seq.sv
// div_seq: multi-cycle RV32M DIV/DIVU/REM/REMU sequencer (restoring, 1 bit/cycle) on the shared alu.
// Ports:
//   clk    in  rising-edge clock
//   reset  in  synchronous active-high reset; aborts any operation without a Done pulse
//   bus    div_if.slave: Div_Start/Div_Op/Div_A/Div_B in, Div_Busy/Div_Done/Div_Result out,
//          Alu_A/Alu_B/Alu_Op out to the alu, Alu_Result in from the alu
// Optional: define DIV_FAST_ZERO_EN to finish divide-by-zero in 2 cycles (IDLE->FIX->DONE).
module div_seq #(
    parameter int DWIDTH = 32
) (
    input logic  clk,
    input logic  reset,
    div_if.slave bus
);
    localparam int CW = $clog2(DWIDTH);
    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
`ifdef DIV_FAST_ZERO_EN
    localparam bit FAST_ZERO = 1'b1;
`else
    localparam bit FAST_ZERO = 1'b0;
`endif

    typedef enum logic [2:0] {IDLE, PREP_A, PREP_B, ITER, FIX, DONE} state_t;

    state_t            state, state_n;
    logic              rem_r, sign_a, sign_b, b_zero;
    logic [DWIDTH-1:0] a_r, b_r, abs_b, r, q, result;
    logic [CW-1:0]     count;
    logic [DWIDTH-1:0] rs, fix_x, alu_a, alu_b;
    logic [3:0]        alu_op;
    logic              ge, negate;

    assign rs     = {r[DWIDTH-2:0], q[DWIDTH-1]};
    assign ge     = rs >= abs_b;
    assign fix_x  = rem_r ? r : q;
    assign negate = rem_r ? sign_a : (sign_a ^ sign_b);

    always_comb begin
        state_n = state;
        alu_a   = '0;
        alu_b   = '0;
        alu_op  = OP_ADD;
        case (state)
            IDLE: begin
                if (bus.Div_Start)
                    state_n = (FAST_ZERO && bus.Div_B == '0) ? FIX : PREP_A;
            end
            PREP_A: begin
                alu_op  = OP_SUB;
                alu_b   = a_r;
                state_n = PREP_B;
            end
            PREP_B: begin
                alu_op  = OP_SUB;
                alu_b   = b_r;
                state_n = ITER;
            end
            ITER: begin
                alu_op  = OP_SUB;
                alu_a   = rs;
                alu_b   = abs_b;
                state_n = (count == CW'(DWIDTH - 1)) ? FIX : ITER;
            end
            FIX: begin
                // Fast zero path never touched the alu; keep it parked at ADD 0,0.
                alu_op  = (FAST_ZERO && b_zero) ? OP_ADD : OP_SUB;
                alu_b   = (FAST_ZERO && b_zero) ? '0 : fix_x;
                state_n = DONE;
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            rem_r  <= 1'b0;
            sign_a <= 1'b0;
            sign_b <= 1'b0;
            b_zero <= 1'b0;
            a_r    <= '0;
            b_r    <= '0;
            abs_b  <= '0;
            r      <= '0;
            q      <= '0;
            count  <= '0;
            result <= '0;
        end else begin
            state <= state_n;
            case (state)
                IDLE: begin
                    if (bus.Div_Start) begin
                        rem_r  <= bus.Div_Op[1];
                        sign_a <= ~bus.Div_Op[0] & bus.Div_A[DWIDTH-1];
                        sign_b <= ~bus.Div_Op[0] & bus.Div_B[DWIDTH-1];
                        b_zero <= bus.Div_B == '0;
                        a_r    <= bus.Div_A;
                        b_r    <= bus.Div_B;
                    end
                end
                // |A| goes straight into the quotient shift register.
                PREP_A: q <= sign_a ? bus.Alu_Result : a_r;
                PREP_B: begin
                    abs_b <= sign_b ? bus.Alu_Result : b_r;
                    r     <= '0;
                    count <= '0;
                end
                ITER: begin
                    r     <= ge ? bus.Alu_Result : rs;
                    q     <= {q[DWIDTH-2:0], ge};
                    count <= count + 1'b1;
                end
                FIX: begin
                    if (b_zero)
                        result <= rem_r ? a_r : '1;
                    else
                        result <= negate ? bus.Alu_Result : fix_x;
                end
                default: ;
            endcase
        end
    end

    assign bus.Div_Busy   = state != IDLE;
    assign bus.Div_Done   = state == DONE;
    assign bus.Div_Result = result;
    assign bus.Alu_A      = alu_a;
    assign bus.Alu_B      = alu_b;
    assign bus.Alu_Op     = alu_op;
endmodule
